// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM encoding, default sizes
// and the index-width helper used by the top and the round-robin arbiter.
package data_mem_arbiter_pkg;

    localparam int DEF_NCORES = 2;
    localparam int DEF_LMEM   = 8;
    localparam int DEF_TAM    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_e;

    // Keeps index vectors at least one bit wide for a single-core build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr, wrapping at
// NCORES-1, and returns a one-hot grant plus the winning index.
module rr_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int NCORES = DEF_NCORES,
    parameter int IDXW   = idx_width(DEF_NCORES)
) (
    input  logic [0:NCORES-1] req,
    input  logic [IDXW-1:0]   ptr,
    output logic [0:NCORES-1] gnt,
    output logic [IDXW-1:0]   gnt_idx,
    output logic              gnt_valid
);

    always_comb begin
        // NOTE: every variable written here is given a default first, so no
        // path through the block can infer a latch.
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < NCORES; k++) begin
            if (!gnt_valid && req[(int'(ptr) + k) % NCORES]) begin
                gnt[(int'(ptr) + k) % NCORES] = 1'b1;
                gnt_idx   = IDXW'((int'(ptr) + k) % NCORES);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sharing of the single-port data memory between NCORES cores,
// one operation in flight. Define MEM_ARB_ADDR_CHECK_EN to flag out-of-range addresses.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int NCORES = DEF_NCORES,
    parameter int LMEM   = DEF_LMEM,
    parameter int TAM    = DEF_TAM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [0:NCORES-1]     core_load,
    input  logic [0:NCORES-1]     core_write,
    input  logic [0:NCORES*TAM-1] core_addr,
    input  logic [0:NCORES*TAM-1] core_din,
    output logic [0:NCORES*TAM-1] core_dout,
    output logic [0:NCORES-1]     core_ack,
    output logic [0:NCORES-1]     core_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [0:LMEM-1]       mem_addr,
    output logic [0:TAM-1]        mem_din,
    input  logic [0:TAM-1]        mem_dout
);

    localparam int IDXW = idx_width(NCORES);

    state_e                state_q, state_d;
    logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]       win_q, win_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [0:LMEM-1]       addr_q, addr_d;
    logic [0:TAM-1]        din_q, din_d;
    logic [0:NCORES*TAM-1] dout_q, dout_d;
    logic [0:NCORES-1]     ack_q, ack_d;
    logic [0:NCORES-1]     cerr_q, cerr_d;

    logic [0:NCORES-1]     req;
    logic [0:NCORES-1]     gnt;
    logic [IDXW-1:0]       gnt_idx;
    logic                  gnt_valid;

    // A core being acked this cycle is masked; a held request is a new transaction.
    assign req = (core_load | core_write) & ~ack_q;

    rr_arbiter #(
        .NCORES (NCORES),
        .IDXW   (IDXW)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        din_d    = din_q;
        dout_d   = dout_q;
        ack_d    = '0;
        cerr_d   = '0;
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    win_d  = gnt_idx;
                    we_d   = |(gnt & core_write);
                    addr_d = core_addr[int'(gnt_idx)*TAM + (TAM-LMEM) +: LMEM];
                    din_d  = core_din[int'(gnt_idx)*TAM +: TAM];
`ifdef MEM_ARB_ADDR_CHECK_EN
                    err_d  = |core_addr[int'(gnt_idx)*TAM +: TAM-LMEM];
`else
                    err_d  = 1'b0;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!err_q) begin
                    mem_en   = 1'b1;
                    mem_we   = we_q;
                    mem_addr = addr_q;
                    mem_din  = din_q;
                end
                state_d = WAIT;
            end
            WAIT: begin
                ack_d[win_q]  = 1'b1;
                cerr_d[win_q] = err_q;
                if (!we_q && !err_q) begin
                    dout_d[int'(win_q)*TAM +: TAM] = mem_dout;
                end
                rr_ptr_d = (win_q == IDXW'(NCORES-1)) ? '0 : win_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            dout_q   <= '0;
            ack_q    <= '0;
            cerr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            ack_q    <= ack_d;
            cerr_q   <= cerr_d;
        end
    end

    assign core_dout = dout_q;
    assign core_ack  = ack_q;
    assign core_err  = cerr_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a small synchronous
// memory model; MEM_ARB_ADDR_CHECK_EN selects the out-of-range expectations.
module tb_data_mem_arbiter;

    localparam int NCORES = 2;
    localparam int LMEM   = 8;
    localparam int TAM    = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [0:NCORES-1]     core_load;
    logic [0:NCORES-1]     core_write;
    logic [0:NCORES*TAM-1] core_addr;
    logic [0:NCORES*TAM-1] core_din;
    logic [0:NCORES*TAM-1] core_dout;
    logic [0:NCORES-1]     core_ack;
    logic [0:NCORES-1]     core_err;
    logic                  mem_en;
    logic                  mem_we;
    logic [0:LMEM-1]       mem_addr;
    logic [0:TAM-1]        mem_din;
    logic [0:TAM-1]        mem_dout;

    int errors = 0;
    int checks = 0;
    int mem_en_cnt = 0;
    int cyc, who, bad_gap, bad_order, n0, n1, en_before;

    logic [0:TAM-1] mem [0:255];

    data_mem_arbiter #(
        .NCORES (NCORES),
        .LMEM   (LMEM),
        .TAM    (TAM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_load  (core_load),
        .core_write (core_write),
        .core_addr  (core_addr),
        .core_din   (core_din),
        .core_dout  (core_dout),
        .core_ack   (core_ack),
        .core_err   (core_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    // Memory model: preload while in reset, read data valid one cycle after mem_en.
    always @(posedge clk) begin
        if (!rst) begin
            mem[8'h05] <= 16'hBEEF;
            mem[8'h00] <= 16'hA0A0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            mem_dout <= mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (rst && mem_en) mem_en_cnt <= mem_en_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int idx, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!core_ack[idx] && n < 20);
    endtask

    task automatic wait_any(output int n, output int w);
        n = 0;
        do begin
            tick();
            n++;
        end while (core_ack == 2'b00 && n < 10);
        if (core_ack == 2'b10)      w = 0;
        else if (core_ack == 2'b01) w = 1;
        else                        w = -1;
    endtask

    initial begin
        rst        = 1'b0;
        core_load  = '0;
        core_write = '0;
        core_addr  = '0;
        core_din   = '0;
        tick();
        tick();
        check("reset_ack",  32'(core_ack),  32'h0);
        check("reset_err",  32'(core_err),  32'h0);
        check("reset_dout", 32'(core_dout), 32'h0);
        check("reset_mem_en", 32'(mem_en),  32'h0);
        rst = 1'b1;
        tick();

        // Single read, core0 at 0x0005: walk ACCESS, WAIT, ack.
        core_addr = {16'h0005, 16'h0000};
        core_load = 2'b10;
        tick();
        check("rd_access_en",   32'(mem_en),   32'h1);
        check("rd_access_we",   32'(mem_we),   32'h0);
        check("rd_access_addr", 32'(mem_addr), 32'h05);
        tick();
        check("rd_wait_en",  32'(mem_en),      32'h0);
        check("rd_wait_ack", 32'(core_ack[0]), 32'h0);
        tick();
        check("rd_ack0",  32'(core_ack),        32'h2);
        check("rd_dout0", 32'(core_dout[0:15]), 32'hBEEF);
        check("rd_err0",  32'(core_err[0]),     32'h0);
        core_load = 2'b00;
        tick();
        check("rd_ack_pulse", 32'(core_ack), 32'h0);

        // Core1 writes 0x1234 to 0x00A3, then reads it back.
        core_addr  = {16'h0000, 16'h00A3};
        core_din   = {16'h0000, 16'h1234};
        core_write = 2'b01;
        wait_ack(1, cyc);
        check("wr_latency", 32'(cyc), 32'd3);
        check("wr_mem",     32'(mem[8'hA3]), 32'h1234);
        check("wr_dout1",   32'(core_dout[16:31]), 32'h0);
        core_write = 2'b00;
        tick();
        core_load = 2'b01;
        wait_ack(1, cyc);
        check("rb_latency", 32'(cyc), 32'd3);
        check("rb_dout1",   32'(core_dout[16:31]), 32'h1234);
        check("rb_dout0",   32'(core_dout[0:15]),  32'hBEEF);
        core_load = 2'b00;
        tick();

        // Both cores load continuously from rr_ptr 0: acks alternate every 3 cycles.
        core_addr = {16'h0005, 16'h00A3};
        core_load = 2'b11;
        bad_gap = 0; bad_order = 0; n0 = 0; n1 = 0;
        for (int t = 0; t < 200; t++) begin
            wait_any(cyc, who);
            if (cyc != 3) bad_gap++;
            if (who != t % 2) bad_order++;
            if (who == 0) n0++;
            else if (who == 1) n1++;
        end
        core_load = 2'b00;
        check("rr_gap_bad",   32'(bad_gap),   32'd0);
        check("rr_order_bad", 32'(bad_order), 32'd0);
        check("rr_core0_cnt", 32'(n0), 32'd100);
        check("rr_core1_cnt", 32'(n1), 32'd100);
        check("rr_dout", 32'(core_dout), {16'hBEEF, 16'h1234});
        tick();

        // Load and write together on core0: treated as a write.
        core_addr  = {16'h0010, 16'h0000};
        core_din   = {16'h5555, 16'h0000};
        core_load  = 2'b10;
        core_write = 2'b10;
        wait_ack(0, cyc);
        check("lw_latency", 32'(cyc), 32'd3);
        check("lw_mem",     32'(mem[8'h10]), 32'h5555);
        check("lw_dout0",   32'(core_dout[0:15]), 32'hBEEF);
        core_load  = 2'b00;
        core_write = 2'b00;
        tick();

        // Reset while core0's read is in WAIT (rr_ptr is 1 beforehand).
        core_addr = {16'h0005, 16'h00A3};
        core_load = 2'b10;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rstw_ack",    32'(core_ack),  32'h0);
        check("rstw_err",    32'(core_err),  32'h0);
        check("rstw_dout",   32'(core_dout), 32'h0);
        check("rstw_mem_en", 32'(mem_en),    32'h0);
        rst = 1'b1;
        core_load = 2'b11;
        wait_any(cyc, who);
        check("rstw_first_who", 32'(who), 32'd0);
        check("rstw_first_lat", 32'(cyc), 32'd3);
        check("rstw_dout0", 32'(core_dout[0:15]), 32'hBEEF);
        core_load = 2'b01;
        wait_any(cyc, who);
        check("rstw_second_who", 32'(who), 32'd1);
        check("rstw_second_lat", 32'(cyc), 32'd3);
        core_load = 2'b00;
        tick();

        // Core1 loads 0x0100: upper bit set beyond LMEM.
        core_addr = {16'h0000, 16'h0100};
        core_load = 2'b01;
        en_before = mem_en_cnt;
        wait_ack(1, cyc);
        check("oor_latency", 32'(cyc), 32'd3);
`ifdef MEM_ARB_ADDR_CHECK_EN
        check("oor_err1",   32'(core_err[1]), 32'h1);
        check("oor_dout1",  32'(core_dout[16:31]), 32'h1234);
        check("oor_mem_en", 32'(mem_en_cnt - en_before), 32'd0);
`else
        check("oor_err1",   32'(core_err[1]), 32'h0);
        check("oor_dout1",  32'(core_dout[16:31]), 32'hA0A0);
        check("oor_mem_en", 32'(mem_en_cnt - en_before), 32'd1);
`endif
        check("oor_dout0", 32'(core_dout[0:15]), 32'hBEEF);
        core_load = 2'b00;
        tick();
        check("oor_err_pulse", 32'(core_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port data memory (DataMEM storage array, 2^LMEM words of TAM bits) between NCORES core load/store ports. Per-core request/acknowledge handshake, round-robin arbitration, one memory operation in flight. Sits between the core load/store units and the memory array; the array is driven only by this block.

## Interface
Parameters:
- NCORES, 2, number of requesting cores
- LMEM, 8, memory address width (2^LMEM words)
- TAM, 16, data and core address width

Ports (all buses [0:N-1], MSB at index 0; core i owns slice [i*TAM +: TAM]):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-low
- core_load  in  NCORES  read request per core
- core_write  in  NCORES  write request per core
- core_addr  in  NCORES*TAM  word address per core
- core_din  in  NCORES*TAM  write data per core
- core_dout  out  NCORES*TAM  read data per core, registered
- core_ack  out  NCORES  one-cycle completion pulse per core
- core_err  out  NCORES  address-range error, valid with ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable (qualified by mem_en)
- mem_addr  out  LMEM  memory address
- mem_din  out  TAM  memory write data
- mem_dout  in  TAM  memory read data, valid 1 cycle after mem_en

## Operation
- Request = core_load[i] | core_write[i]. Core holds request, addr and din stable until its ack.
- Both load and write set: treated as write; no read data returned.
- FSM states: IDLE, ACCESS, WAIT.
  - IDLE: eligible requests present -> select winner, latch op/addr/din/index -> ACCESS. None -> stay.
  - ACCESS: mem_en=1, mem_we=latched write, mem_addr=latched addr[TAM-LMEM:TAM-1], mem_din=latched din -> WAIT.
  - WAIT: on exit edge, read: core_dout[winner] <= mem_dout; core_ack[winner] <= 1; rr_ptr <= (winner+1) mod NCORES -> IDLE.
- Round-robin: search starts at rr_ptr, ascending index, wrap at NCORES-1 -> 0.
- Eligibility: a core whose ack is high this cycle is masked; a request still high after ack is a new transaction.
- core_dout[i] holds last read result for core i until its next read completes; writes leave it unchanged.
- mem_en, mem_we, mem_addr, mem_din are 0 outside ACCESS.

## Timing
- Reset (rst low at a rising edge): state IDLE, rr_ptr 0, core_dout 0, core_ack 0, core_err 0, mem_* 0. Transaction in flight is abandoned, no ack issued.
- Request visible in IDLE cycle n -> ACCESS n+1 -> WAIT n+2 -> ack and dout valid cycle n+3.
- Back-to-back: next grant evaluated in cycle n+3 (IDLE); sustained rate one transaction per 3 cycles.
- Simultaneous requests: one granted, others wait; with all NCORES requesting continuously, each served once per NCORES transactions.
- Requests changing while not granted: sampled anew each IDLE cycle; no latching before grant.

## Configuration
- MEM_ARB_ADDR_CHECK_EN defined: core address with any nonzero bit in addr[0:TAM-LMEM-1] -> no memory access (mem_en stays 0 in ACCESS), ack with core_err=1, core_dout unchanged on read. Same 3-cycle latency.
- Undefined: upper address bits ignored (wrap-around to low LMEM bits); core_err tied 0.

## Structure
- Shared package: FSM state encoding (IDLE, ACCESS, WAIT), default NCORES/LMEM/TAM constants.
- Sub-module rr_arbiter: NCORES request vector + rr_ptr -> one-hot grant and index, purely combinational.

## Test plan
- Single read: mem[0x05]=0xBEEF preloaded, core0 load addr 0x0005 -> ack0 3 cycles later, core_dout0=0xBEEF, err0=0.
- Write then read: core1 write 0x00A3 data 0x1234, then load 0x00A3 -> second ack, core_dout1=0x1234; core_dout0 unchanged.
- Contention: both cores load continuously from rr_ptr=0 -> acks alternate 0,1,0,1 every 3 cycles; no core starved over 200 transactions.
- Load+write set together on core0 addr 0x0010 data 0x5555 -> memory written 0x5555, core_dout0 unchanged.
- Reset in WAIT of core0 read -> no ack0, all outputs 0 next cycle, rr_ptr 0; held request re-served after rst high.
- Address 0x0100 with LMEM=8: macro defined -> ack with err=1, mem_en never high; undefined -> accesses mem[0x00].
